keypad_debouncer: RTL and testbench
===================================

Name: keypad_debouncer

Overview:
- Sits between membranedriver's 4-bit scan output and safecontrol's invalue input.
- Debounces raw key codes and emits exactly one clean key event per physical press.
- Suppresses repeats while a key is held.
- Raises an entry-abort pulse when the keypad stays idle too long after a key, so safecontrol can discard a partial code.

Parameters:
- DEBOUNCE_CYC, 8, consecutive matching samples needed to accept a press or a release (legal range 2..255).
- TIMEOUT_CYC, 1024, idle cycles after a release before entry_abort fires; 0 disables the abort.

Ports:
- clk  input  1  single clock; rising edge only.
- rst  input  1  synchronous, active-high reset.
- raw_code  input  4  scanner output, synchronous to clk.
  - Codes 0-9 are digits, 4'hA = '*', 4'hB = '#'.
  - 4'hF = no key; codes 4'hC-4'hE are treated as no key.
- key_code  output  4  accepted code during the key_valid cycle; 4'hF in all other cycles. Drives safecontrol invalue directly.
- key_valid  output  1  one-cycle pulse per debounced press.
- key_held  output  1  high while in HELD or RELEASE_WAIT.
- entry_abort  output  1  one-cycle pulse on idle timeout.

Behaviour:
- Definitions:
  - "Valid" means raw_code <= 4'hB.
  - All outputs are registered; all state changes happen on the rising clk edge.
- Reset (rst=1):
  - state=IDLE, key_code=4'hF, key_valid=0, key_held=0, entry_abort=0.
  - cand=4'hF, deb_cnt=0, tmo_cnt=0, armed=0.
  - Reset mid-press emits nothing. A key still down after reset is debounced as a fresh press.
- IDLE:
  - raw valid: cand<=raw, deb_cnt<=1, go to PRESS_WAIT.
  - raw not valid: stay in IDLE.
- PRESS_WAIT:
  - raw==cand and deb_cnt==DEBOUNCE_CYC-1: go to HELD, key_valid<=1, key_code<=cand.
  - raw==cand otherwise: deb_cnt++.
  - raw valid but !=cand: restart with cand<=raw, deb_cnt<=1.
  - raw not valid: return to IDLE, no event.
- HELD:
  - raw not valid: deb_cnt<=1, go to RELEASE_WAIT.
  - Any valid raw, same or different code: ignored. No rollover; the key must be released first.
- RELEASE_WAIT:
  - raw not valid for DEBOUNCE_CYC consecutive samples (deb_cnt reaches DEBOUNCE_CYC-1 while raw stays not valid): go to IDLE.
  - Any valid raw: back to HELD, no new event.
- Latency: key_valid is high in the cycle after the DEBOUNCE_CYC-th consecutive matching sample, i.e. DEBOUNCE_CYC edges after the first matching sample.
- key_code/key_valid:
  - key_valid is high for exactly 1 cycle.
  - key_code equals the accepted code in that cycle, and 4'hF otherwise.
- Timeout:
  - armed<=1 on each key_valid.
  - tmo_cnt counts only while state==IDLE and armed=1; it clears to 0 in any other state.
  - When tmo_cnt reaches TIMEOUT_CYC-1 in IDLE: entry_abort<=1 for one cycle, armed<=0, tmo_cnt<=0.
- Simultaneous events:
  - Expiry cycle coincides with a valid raw in IDLE: the press wins; no abort, counter clears.
  - A bounce that returns PRESS_WAIT to IDLE restarts tmo_cnt from 0 (armed unchanged).
- Counter widths: $clog2(param+1). Counters never wrap; they saturate/clear per the rules above.
- TIMEOUT_CYC=0: entry_abort is never asserted.

Decomposition:
- Shared package (keypad_pkg):
  - key code constants: KEY_NONE=4'hF, KEY_STAR=4'hA, KEY_HASH=4'hB, KEY_MAX_VALID=4'hB.
  - 2-bit state enum: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- One sub-module, idle_timeout_timer:
  - ports: clk, rst, arm, run, pulse.
  - holds armed/tmo_cnt and produces entry_abort.
- FSM and debounce counter stay in the top of this block.

Test Plan (DEBOUNCE_CYC=4, TIMEOUT_CYC=20):
1. Clean press: raw=4'h5 for 10 cycles, then 4'hF -> key_valid one cycle, 4 edges after the first 4'h5 sample, key_code=4'h5 in that cycle only; key_held high until 4 idle samples, then low.
2. Bounce: raw toggles 4'h7/4'hF every 2 cycles, then 4'h7 steady -> no event during toggling; one event with code 4'h7 after 4 steady samples.
3. Hold and second key: hold 4'h3 for 50 cycles with 4'h9 injected for 3 cycles mid-hold -> exactly one event (4'h3); no event for 4'h9; no repeat.
4. Release glitch: after 4'hA is accepted, raw=4'hF for 2 cycles, then 4'hA for 1 cycle, then 4'hF for 6 cycles -> single event total; key_held falls 4 cycles into the final idle run.
5. Timeout: press and release 4'h1, then idle -> entry_abort pulses exactly once, 20 cycles after entering IDLE; no further pulses while idle. Same sequence with a press starting on the expiry cycle -> no abort.
6. Reset mid-press: rst=1 for 1 cycle at deb_cnt=2 while raw=4'h8 stays -> all outputs return to reset values; the event fires 4 edges after rst deasserts, code 4'h8. Codes 4'hC-4'hE held for 10 cycles -> no event.

Source files
------------

// File: rtl/keypad_debouncer_pkg.sv
// keypad_pkg: shared definitions for the keypad debouncer slice.
// Holds the key code constants used between the membrane scanner and the
// safe controller, and the state encoding of the debounce FSM.
package keypad_pkg;

  // Scanner codes: 0-9 digits, A = '*', B = '#', F = no key.
  // Codes C-E never come from a real key and are treated like "no key".
  localparam logic [3:0] KEY_NONE      = 4'hF;
  localparam logic [3:0] KEY_STAR      = 4'hA;
  localparam logic [3:0] KEY_HASH      = 4'hB;
  localparam logic [3:0] KEY_MAX_VALID = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } kp_state_e;

  // A raw sample counts as a key only if it is a digit, '*' or '#'.
  function automatic logic is_valid_key(input logic [3:0] code);
    return code <= KEY_MAX_VALID;
  endfunction

endpackage

// File: rtl/keypad_debouncer_if.sv
// keypad_debouncer_if: bundle between the scanner/controller side and the
// debouncer.
//   raw_code    : 4-bit scanner sample, driven by the master
//   key_code    : accepted code during key_valid, 4'hF otherwise
//   key_valid   : one-cycle pulse per debounced press
//   key_held    : high while a key is considered down
//   entry_abort : one-cycle pulse when the keypad idles too long
// master = scanner/consumer side, slave = the debouncer itself.
interface keypad_debouncer_if;

  logic [3:0] raw_code;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       entry_abort;

  modport master (
    output raw_code,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  entry_abort
  );

  modport slave (
    input  raw_code,
    output key_code,
    output key_valid,
    output key_held,
    output entry_abort
  );

endinterface

// File: rtl/keypad_debouncer_timer.sv
// idle_timeout_timer: counts idle cycles after an accepted key and fires a
// one-cycle pulse when the keypad has been quiet for TIMEOUT_CYC cycles.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   arm   : pulse that (re)arms the timer, one per accepted key
//   run   : high while the keypad is idle and counting is allowed
//   pulse : registered one-cycle timeout pulse
// TIMEOUT_CYC = 0 disables the timer completely.
module idle_timeout_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic run,
  output logic pulse
);

  // Keep at least one bit so the disabled configuration still elaborates.
  localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1);
  localparam logic ENABLED = (TIMEOUT_CYC != 0);

  logic          armed;
  logic [TW-1:0] tmo_cnt;

  // The counter only advances while armed and idle; leaving idle (including
  // a press landing on the expiry cycle) clears it, so the press wins.
  // Expiry disarms the timer so the abort fires once per entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b0;
      tmo_cnt <= '0;
      pulse   <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (arm) begin
        armed <= 1'b1;
      end
      if (ENABLED && run && armed) begin
        if (tmo_cnt == LAST) begin
          pulse   <= 1'b1;
          armed   <= 1'b0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: turns noisy 4-bit scanner samples into one clean key
// event per physical press, suppresses repeats while held, and raises an
// entry-abort pulse after a long idle period following a key.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   kif : keypad_debouncer_if.slave (raw_code in; key_code, key_valid,
//         key_held, entry_abort out, all registered)
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 8,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_debouncer_if.slave    kif
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);

  kp_state_e     state;
  logic [3:0]    cand;
  logic [DW-1:0] deb_cnt;
  logic          raw_valid;
  logic          timer_run;

  assign raw_valid = is_valid_key(kif.raw_code);

  // Idle time only accumulates while nothing is pressed, so a valid sample
  // arriving on the expiry cycle suppresses the abort.
  assign timer_run = (state == IDLE) && !raw_valid;

  // Debounce FSM. deb_cnt counts consecutive agreeing samples, starting at 1
  // on the sample that enters a wait state, so the transition happens on the
  // DEBOUNCE_CYC-th agreeing sample. key_held is registered alongside the
  // state so it tracks HELD/RELEASE_WAIT exactly. Once HELD, other codes are
  // ignored until a full release is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= KEY_NONE;
      deb_cnt   <= '0;
      kif.key_code  <= KEY_NONE;
      kif.key_valid <= 1'b0;
      kif.key_held  <= 1'b0;
    end else begin
      kif.key_valid <= 1'b0;
      kif.key_code  <= KEY_NONE;
      case (state)
        IDLE: begin
          if (raw_valid) begin
            cand    <= kif.raw_code;
            deb_cnt <= DW'(1);
            state   <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!raw_valid) begin
            state <= IDLE;
          end else if (kif.raw_code != cand) begin
            cand    <= kif.raw_code;
            deb_cnt <= DW'(1);
          end else if (deb_cnt == DEB_LAST) begin
            state         <= HELD;
            kif.key_valid <= 1'b1;
            kif.key_code  <= cand;
            kif.key_held  <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        HELD: begin
          if (!raw_valid) begin
            deb_cnt <= DW'(1);
            state   <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (raw_valid) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state        <= IDLE;
            kif.key_held <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  idle_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .arm   (kif.key_valid),
    .run   (timer_run),
    .pulse (kif.entry_abort)
  );

endmodule

// File: tb/tb_keypad_debouncer.sv
// tb_keypad_debouncer: directed bench for keypad_debouncer with
// DEBOUNCE_CYC=4 and TIMEOUT_CYC=20. Inputs change 1 time unit after each
// rising edge; outputs are observed at the same point, so every observation
// reflects the edge just taken.
module tb_keypad_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ev_cnt  = 0;
  int abort_cnt = 0;
  logic [3:0] last_code = 4'hF;

  keypad_debouncer_if kif ();

  keypad_debouncer #(
    .DEBOUNCE_CYC(4),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one raw code for n edges, tallying events and checking that
  // key_code rests at 4'hF whenever key_valid is low.
  task automatic applyStimulus(input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      kif.raw_code = code;
      @(posedge clk);
      #1;
      if (kif.key_valid) begin
        ev_cnt++;
        last_code = kif.key_code;
      end else begin
        checkOutput("idle_key_code", kif.key_code, 4'hF);
      end
      if (kif.entry_abort) abort_cnt++;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    kif.raw_code = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ev_cnt = 0;
    abort_cnt = 0;
    last_code = 4'hF;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_code"},  kif.key_code,    4'hF);
    checkOutput({tag, "_valid"}, kif.key_valid,   1'b0);
    checkOutput({tag, "_held"},  kif.key_held,    1'b0);
    checkOutput({tag, "_abort"}, kif.entry_abort, 1'b0);
  endtask

  initial begin
    kif.raw_code = 4'hF;
    @(posedge clk);
    #1;
    checkResetState("rst");
    rst = 1'b0;

    // 1. Clean press of 5: event on the 4th edge, released after 4 idle samples.
    $display("[TB] test 1: clean press");
    doReset();
    applyStimulus(4'h5, 3);
    checkOutput("t1_early_valid", kif.key_valid, 1'b0);
    applyStimulus(4'h5, 1);
    checkOutput("t1_valid", kif.key_valid, 1'b1);
    checkOutput("t1_code", kif.key_code, 4'h5);
    checkOutput("t1_held", kif.key_held, 1'b1);
    applyStimulus(4'h5, 1);
    checkOutput("t1_valid_drop", kif.key_valid, 1'b0);
    applyStimulus(4'h5, 5);
    applyStimulus(4'hF, 3);
    checkOutput("t1_held_late", kif.key_held, 1'b1);
    applyStimulus(4'hF, 1);
    checkOutput("t1_released", kif.key_held, 1'b0);
    checkOutput("t1_events", ev_cnt, 1);

    // 2. Bounce between 7 and no-key, then settle on 7.
    $display("[TB] test 2: bounce");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h7, 2);
      applyStimulus(4'hF, 2);
    end
    checkOutput("t2_no_bounce_ev", ev_cnt, 0);
    applyStimulus(4'h7, 3);
    checkOutput("t2_early_valid", kif.key_valid, 1'b0);
    applyStimulus(4'h7, 1);
    checkOutput("t2_valid", kif.key_valid, 1'b1);
    checkOutput("t2_code", kif.key_code, 4'h7);
    applyStimulus(4'hF, 4);
    checkOutput("t2_events", ev_cnt, 1);

    // 3. Hold 3 with 9 injected mid-hold: one event, no rollover, no repeat.
    $display("[TB] test 3: hold with second key");
    doReset();
    applyStimulus(4'h3, 20);
    applyStimulus(4'h9, 3);
    applyStimulus(4'h3, 27);
    checkOutput("t3_events", ev_cnt, 1);
    checkOutput("t3_code", last_code, 4'h3);
    checkOutput("t3_held", kif.key_held, 1'b1);
    applyStimulus(4'hF, 4);
    checkOutput("t3_released", kif.key_held, 1'b0);

    // 4. Release glitch on '*': the brief re-press produces no new event.
    $display("[TB] test 4: release glitch");
    doReset();
    applyStimulus(4'hA, 4);
    checkOutput("t4_code", kif.key_code, 4'hA);
    applyStimulus(4'hF, 2);
    applyStimulus(4'hA, 1);
    checkOutput("t4_glitch_held", kif.key_held, 1'b1);
    applyStimulus(4'hF, 3);
    checkOutput("t4_held_late", kif.key_held, 1'b1);
    applyStimulus(4'hF, 1);
    checkOutput("t4_released", kif.key_held, 1'b0);
    applyStimulus(4'hF, 2);
    checkOutput("t4_events", ev_cnt, 1);

    // 5a. Timeout fires once, 20 edges after IDLE is re-entered.
    $display("[TB] test 5: idle timeout");
    doReset();
    applyStimulus(4'h1, 4);
    applyStimulus(4'hF, 4);
    applyStimulus(4'hF, 19);
    checkOutput("t5_no_early_abort", abort_cnt, 0);
    applyStimulus(4'hF, 1);
    checkOutput("t5_abort", kif.entry_abort, 1'b1);
    applyStimulus(4'hF, 1);
    checkOutput("t5_abort_drop", kif.entry_abort, 1'b0);
    applyStimulus(4'hF, 40);
    checkOutput("t5_abort_once", abort_cnt, 1);

    // 5b. A press landing on the expiry cycle wins over the abort.
    doReset();
    applyStimulus(4'h1, 4);
    applyStimulus(4'hF, 4);
    applyStimulus(4'hF, 19);
    applyStimulus(4'h1, 1);
    checkOutput("t5_press_wins", kif.entry_abort, 1'b0);
    applyStimulus(4'h1, 3);
    checkOutput("t5_second_event", ev_cnt, 2);
    applyStimulus(4'hF, 14);
    checkOutput("t5_no_abort", abort_cnt, 0);

    // 6. Reset in the middle of debouncing 8, then unused codes C-E.
    $display("[TB] test 6: reset mid-press");
    doReset();
    applyStimulus(4'h8, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("t6_rst");
    rst = 1'b0;
    applyStimulus(4'h8, 3);
    checkOutput("t6_early_valid", kif.key_valid, 1'b0);
    applyStimulus(4'h8, 1);
    checkOutput("t6_valid", kif.key_valid, 1'b1);
    checkOutput("t6_code", kif.key_code, 4'h8);
    checkOutput("t6_events", ev_cnt, 1);
    applyStimulus(4'hF, 4);
    doReset();
    applyStimulus(4'hC, 10);
    applyStimulus(4'hD, 10);
    applyStimulus(4'hE, 10);
    checkOutput("t6_invalid_events", ev_cnt, 0);
    checkOutput("t6_invalid_held", kif.key_held, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
